tone_arbiter: RTL and testbench

//  Shares one square-wave tone voice between NUM_REQ sound requesters, e.g. game events.

---
 rtl/tone_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_tone_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_arbiter.sv
// -----------------------------------------------------------------------------
// tone_arbiter
//   Shares one square-wave tone voice between NUM_REQ requesters. Index 0 has
//   the highest priority and preempts any lower-priority note in progress.
//   Each note plays for max(D,1)*TICK_DIV clocks with a 3-bit volume PWM, then
//   a silent gap of GAP_CLKS clocks follows before the next arbitration.
//
// Ports
//   i_Clk      system clock, all logic on posedge
//   i_Reset_n  asynchronous active-low reset
//   i_Req      level request per requester (held until o_Ack)
//   i_Period   per-requester half-period in clocks, 0 = rest
//   i_Dur      per-requester duration in ticks, 0 treated as 1
//   i_Vol      per-requester volume 0..7
//   i_Mute     forces o_Out low and blocks new grants
//   o_Grant    one-hot owner of the voice while playing
//   o_Ack      one-cycle pulse when a request is accepted
//   o_Done     one-cycle pulse when a note completes without preemption
//   o_Busy     high while playing or in the gap
//   o_Out      registered tone output
// -----------------------------------------------------------------------------
module tone_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int PERIOD_W = 16,
  parameter int DUR_W    = 10,
  parameter int TICK_DIV = 25000,
  parameter int GAP_CLKS = 250000
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset_n,
  input  logic [NUM_REQ-1:0]            i_Req,
  input  logic [NUM_REQ*PERIOD_W-1:0]   i_Period,
  input  logic [NUM_REQ*DUR_W-1:0]      i_Dur,
  input  logic [NUM_REQ*3-1:0]          i_Vol,
  input  logic                          i_Mute,
  output logic [NUM_REQ-1:0]            o_Grant,
  output logic [NUM_REQ-1:0]            o_Ack,
  output logic                          o_Done,
  output logic                          o_Busy,
  output logic                          o_Out
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W  = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CLKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [DUR_W-1:0]    rem_q, rem_d;
  logic [2:0]          vol_q, vol_d;
  logic [PERIOD_W-1:0] half_q, half_d;
  logic                phase_q, phase_d;
  logic [2:0]          pwm_q, pwm_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                out_q, out_d;

  logic                req_any;
  logic [IDX_W-1:0]    low_idx;
  logic [PERIOD_W-1:0] sel_period;
  logic [DUR_W-1:0]    sel_dur;
  logic [2:0]          sel_vol;
  logic                start_note;
  logic                tone_en;

  // Lowest-index active request and its parameters; scanning downwards lets
  // the lowest set index overwrite any higher one.
  always_comb begin
    req_any    = |i_Req;
    low_idx    = '0;
    sel_period = '0;
    sel_dur    = '0;
    sel_vol    = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      low_idx    = i_Req[i] ? IDX_W'(i) : low_idx;
      sel_period = i_Req[i] ? i_Period[i*PERIOD_W +: PERIOD_W] : sel_period;
      sel_dur    = i_Req[i] ? i_Dur[i*DUR_W +: DUR_W] : sel_dur;
      sel_vol    = i_Req[i] ? i_Vol[i*3 +: 3] : sel_vol;
    end
  end

  // Start a note from IDLE, or preempt when a strictly higher-priority request
  // appears during PLAY. Mute blocks both.
  always_comb begin
    start_note = req_any & ~i_Mute &
                 ((state_q == S_IDLE) |
                  ((state_q == S_PLAY) & (low_idx < owner_q)));
    tone_en    = (state_q == S_PLAY) & phase_q & (period_q != '0) &
                 ({1'b0, pwm_q} <= {1'b0, vol_q});
  end

  // Next-state and output computation.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    period_d = period_q;
    rem_d    = rem_q;
    vol_d    = vol_q;
    half_d   = half_q;
    phase_d  = phase_q;
    pwm_d    = pwm_q;
    tick_d   = tick_q;
    gap_d    = gap_q;
    grant_d  = grant_q;
    ack_d    = '0;
    done_d   = 1'b0;
    out_d    = tone_en & ~i_Mute;

    if (start_note) begin
      state_d  = S_PLAY;
      owner_d  = low_idx;
      period_d = sel_period;
      rem_d    = (sel_dur == '0) ? DUR_W'(1) : sel_dur;
      vol_d    = sel_vol;
      half_d   = '0;
      phase_d  = 1'b1;
      pwm_d    = 3'd0;
      tick_d   = '0;
      gap_d    = '0;
      grant_d  = NUM_REQ'(1) << low_idx;
      ack_d    = NUM_REQ'(1) << low_idx;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_PLAY: begin
          pwm_d = pwm_q + 3'd1;
          // A rest (period 0) keeps the half-period counter parked.
          if (period_q == '0) begin
            half_d = '0;
          end else if (half_q == (period_q - PERIOD_W'(1))) begin
            half_d  = '0;
            phase_d = ~phase_q;
          end else begin
            half_d = half_q + PERIOD_W'(1);
          end
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rem_q == DUR_W'(1)) begin
              state_d = S_GAP;
              gap_d   = '0;
              grant_d = '0;
              done_d  = 1'b1;
            end else begin
              rem_d = rem_q - DUR_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = S_IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      period_q <= '0;
      rem_q    <= '0;
      vol_q    <= 3'd0;
      half_q   <= '0;
      phase_q  <= 1'b0;
      pwm_q    <= 3'd0;
      tick_q   <= '0;
      gap_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      period_q <= period_d;
      rem_q    <= rem_d;
      vol_q    <= vol_d;
      half_q   <= half_d;
      phase_q  <= phase_d;
      pwm_q    <= pwm_d;
      tick_q   <= tick_d;
      gap_q    <= gap_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      out_q    <= out_d;
    end
  end

  assign o_Grant = grant_q;
  assign o_Ack   = ack_q;
  assign o_Done  = done_q;
  assign o_Busy  = busy_q;
  assign o_Out   = out_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tone_arbiter
//   Self-checking bench for tone_arbiter with TICK_DIV=10, GAP_CLKS=4,
//   NUM_REQ=4: a table of single notes, hand-written multi-cycle sequences
//   (reset mid-note, back-to-back arbitration, preemption, mute), then random
//   traffic compared every cycle with a time-based reference model.
// -----------------------------------------------------------------------------
module tb_tone_arbiter;

  localparam int NR = 4;
  localparam int PW = 16;
  localparam int DW = 10;
  localparam int TD = 10;
  localparam int GC = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*PW-1:0]  per;
  logic [NR*DW-1:0]  dur;
  logic [NR*3-1:0]   vol;
  logic              mute;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     ack;
  logic              done;
  logic              busy;
  logic              out;

  int checks   = 0;
  int failures = 0;

  tone_arbiter #(
    .NUM_REQ (NR),
    .PERIOD_W(PW),
    .DUR_W   (DW),
    .TICK_DIV(TD),
    .GAP_CLKS(GC)
  ) dut (
    .i_Clk    (clk),
    .i_Reset_n(rst_n),
    .i_Req    (req),
    .i_Period (per),
    .i_Dur    (dur),
    .i_Vol    (vol),
    .i_Mute   (mute),
    .o_Grant  (grant),
    .o_Ack    (ack),
    .o_Done   (done),
    .o_Busy   (busy),
    .o_Out    (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int p;
    int d;
    int v;
    int exp_clks;
    int exp_high;
  } note_t;

  note_t tbl [6];

  // reference model state
  int          m_mode;   // 0 idle, 1 play, 2 gap
  int          m_owner;
  int          m_t;
  int          m_len;
  int          m_p;
  int          m_v;
  int          m_g;
  logic [NR-1:0] e_grant;
  logic [NR-1:0] e_ack;
  logic        e_done;
  logic        e_out;
  logic        e_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_params(input int idx, input int p, input int d, input int v);
    per[idx*PW +: PW] = PW'(p);
    dur[idx*DW +: DW] = DW'(d);
    vol[idx*3 +: 3]   = 3'(v);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (ack == '0 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || ack != '0) && n < 300) begin
      tick();
      n++;
    end
    check("drain_idle", {31'd0, busy}, 32'd0);
  endtask

  // Model: a note is described by its elapsed time t; the tone and PWM are
  // pure arithmetic on t.
  task automatic model_step();
    int  low;
    int  d;
    bit  tone;
    bit  start;
    low = -1;
    for (int i = NR - 1; i >= 0; i--) begin
      if (req[i]) low = i;
    end
    tone   = (m_mode == 1) && (m_p != 0) && (((m_t / m_p) % 2) == 0) && ((m_t % 8) <= m_v);
    e_out  = tone && !mute;
    e_ack  = '0;
    e_done = 1'b0;
    start  = (low >= 0) && !mute && (m_mode == 0 || (m_mode == 1 && low < m_owner));
    if (start) begin
      m_mode  = 1;
      m_owner = low;
      m_t     = 0;
      m_p     = int'(per[low*PW +: PW]);
      d       = int'(dur[low*DW +: DW]);
      m_len   = ((d == 0) ? 1 : d) * TD;
      m_v     = int'(vol[low*3 +: 3]);
      e_grant = NR'(1) << low;
      e_ack   = NR'(1) << low;
    end else if (m_mode == 1) begin
      if (m_t == m_len - 1) begin
        m_mode  = 2;
        m_g     = 0;
        e_grant = '0;
        e_done  = 1'b1;
      end else begin
        m_t++;
      end
    end else if (m_mode == 2) begin
      if (m_g == GC - 1) m_mode = 0;
      else m_g++;
    end
    e_busy = (m_mode != 0);
  endtask

  initial begin
    int n;
    int gcnt;
    int hcnt;
    int bcnt;
    int dcnt;
    int acnt;
    logic [NR-1:0] exp_oh;

    tbl[0] = '{2, 5, 3, 7, 30, 15};
    tbl[1] = '{0, 8, 2, 0, 20, 2};
    tbl[2] = '{3, 0, 1, 7, 10, 0};
    tbl[3] = '{1, 1, 0, 7, 10, 5};
    tbl[4] = '{2, 3, 1, 3, 10, 4};
    tbl[5] = '{0, 2, 1, 1, 10, 4};

    rst_n = 1'b0;
    req   = '0;
    per   = '0;
    dur   = '0;
    vol   = '0;
    mute  = 1'b0;
    #3;
    check("reset_outputs", {20'd0, grant, ack, done, busy, out, 1'b0}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", {27'd0, grant, busy}, 32'd0);

    // table of isolated notes
    for (int e = 0; e < 6; e++) begin
      exp_oh = NR'(1) << tbl[e].idx;
      set_params(tbl[e].idx, tbl[e].p, tbl[e].d, tbl[e].v);
      req[tbl[e].idx] = 1'b1;
      wait_ack(n);
      check("tbl_ack", {28'd0, ack}, {28'd0, exp_oh});
      check("tbl_grant", {28'd0, grant}, {28'd0, exp_oh});
      req = '0;
      gcnt = 0;
      hcnt = 0;
      n = 0;
      forever begin
        if (grant != '0) gcnt++;
        if (out) hcnt++;
        if (done || n >= 300) break;
        tick();
        n++;
      end
      check("tbl_done_seen", {31'd0, done}, 32'd1);
      check("tbl_note_clks", gcnt, tbl[e].exp_clks);
      check("tbl_high_clks", hcnt, tbl[e].exp_high);
      bcnt = 0;
      while (busy && bcnt < 50) begin
        bcnt++;
        tick();
      end
      check("tbl_gap_busy", bcnt, GC);
    end

    // reset asserted in the middle of a note
    set_params(1, 3, 5, 7);
    req[1] = 1'b1;
    wait_ack(n);
    req = '0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midnote_reset", {20'd0, grant, ack, done, busy, out, 1'b0}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", {27'd0, grant, busy}, 32'd0);

    // simultaneous requests 1 and 3: 1 first, 3 after gap+1 clocks
    set_params(1, 2, 1, 7);
    set_params(3, 2, 1, 7);
    req = 4'b1010;
    wait_ack(n);
    check("both_first_ack", {28'd0, ack}, 32'd2);
    req[1] = 1'b0;
    wait_done(n);
    check("both_first_len", n, TD);
    n = 0;
    while (ack == '0 && n < 50) begin
      tick();
      n++;
    end
    check("both_second_spacing", n, GC + 1);
    check("both_second_ack", {28'd0, ack}, 32'd8);
    req = '0;
    drain();

    // preemption of requester 2 by requester 0 at clk 12
    set_params(2, 5, 3, 7);
    set_params(0, 4, 1, 7);
    req[2] = 1'b1;
    wait_ack(n);
    req[2] = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    req[0] = 1'b1;
    tick();
    check("preempt_ack", {28'd0, ack}, 32'd1);
    check("preempt_grant", {28'd0, grant}, 32'd1);
    req[0] = 1'b0;
    wait_done(n);
    check("preempt_note_len", n, TD);
    tick();
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) dcnt++;
      tick();
    end
    check("preempt_no_done_low", dcnt, 0);
    drain();

    // mute blocks grants
    mute = 1'b1;
    set_params(0, 2, 1, 7);
    req[0] = 1'b1;
    acnt = 0;
    bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ack != '0) acnt++;
      if (busy) bcnt++;
    end
    check("mute_no_ack", acnt, 0);
    check("mute_no_busy", bcnt, 0);
    req = '0;
    mute = 1'b0;
    tick();

    // mute during a note: silent output, done at the normal time
    set_params(0, 2, 2, 7);
    req[0] = 1'b1;
    wait_ack(n);
    req = '0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n++;
    end
    mute = 1'b1;
    hcnt = 0;
    while (!done && n < 100) begin
      tick();
      n++;
      if (out) hcnt++;
    end
    check("mute_mid_out", hcnt, 0);
    check("mute_mid_done_time", n, 2 * TD);
    mute = 1'b0;
    drain();

    // random traffic against the reference model
    rst_n = 1'b0;
    req   = '0;
    mute  = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    m_mode  = 0;
    m_owner = 0;
    m_t     = 0;
    m_len   = 1;
    m_p     = 0;
    m_v     = 0;
    m_g     = 0;
    e_grant = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 29) == 0) begin
          set_params(i, $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 7));
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 199) == 0) begin
          req[i] = 1'b0;
        end
      end
      if (mute) begin
        if ($urandom_range(0, 9) == 0) mute = 1'b0;
      end else begin
        if ($urandom_range(0, 149) == 0) mute = 1'b1;
      end
      @(posedge clk);
      model_step();
      #1;
      check("rnd_grant", {28'd0, grant}, {28'd0, e_grant});
      check("rnd_ack", {28'd0, ack}, {28'd0, e_ack});
      check("rnd_done", {31'd0, done}, {31'd0, e_done});
      check("rnd_busy", {31'd0, busy}, {31'd0, e_busy});
      check("rnd_out", {31'd0, out}, {31'd0, e_out});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
